// File: rtl/sync_uart_tx.sv
// ============================================================================
// sync_uart_tx : serialises one message as 0x7E, opt, len, data, CRC-32/MPEG-2.
// Macro SYNC_UART_TX_CRC_EN builds the CRC; without it the 4 CRC bytes are 0x00.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_uart_tx #(
  parameter int BYTE_SIZE    = 8,
  parameter int MAX_MSG_LEN  = (1 << BYTE_SIZE) - 1,
  parameter int IN_DATA_SIZE = $clog2(MAX_MSG_LEN) * BYTE_SIZE
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    baud_en,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [BYTE_SIZE-1:0]    i_opt,
  input  logic [BYTE_SIZE-1:0]    i_len,
  input  logic [IN_DATA_SIZE-1:0] i_data,
  output logic                    o_tx,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int                   DATA_BYTES = $clog2(MAX_MSG_LEN);
  localparam int                   IDX_W      = $clog2(BYTE_SIZE);
  localparam logic [3:0]           BIT_LAST   = 4'(BYTE_SIZE + 1);
  localparam logic [BYTE_SIZE-1:0] INIT_BYTE  = BYTE_SIZE'(8'h7E);
  localparam logic [BYTE_SIZE-1:0] MAX_LEN    = BYTE_SIZE'(DATA_BYTES);
  localparam logic [BYTE_SIZE-1:0] CSM_LAST   = BYTE_SIZE'(3);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_OPT  = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_CSM  = 3'd5,
    S_DONE = 3'd6
  } state_e;

  state_e                  state_q;
  logic [3:0]              bit_cnt_q;
  logic [BYTE_SIZE-1:0]    byte_cnt_q;
  logic [BYTE_SIZE-1:0]    opt_q;
  logic [BYTE_SIZE-1:0]    len_q;
  logic [IN_DATA_SIZE-1:0] data_q;
  logic                    tx_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic                    accept;
  logic                    len_ok;
  logic [BYTE_SIZE-1:0]    pad_bytes;
  logic [IN_DATA_SIZE-1:0] data_aligned_d;
  logic [BYTE_SIZE-1:0]    cur_byte;
  logic [BYTE_SIZE-1:0]    csm_byte;
  logic [IDX_W-1:0]        bit_idx;
  logic                    is_data_bit;
  logic                    tx_d;

  // Payload is left-aligned on capture so DATA always sends the top byte.
  always_comb begin
    accept         = (state_q == S_IDLE) && i_valid && ready_q;
    len_ok         = (i_len != '0) && (i_len <= MAX_LEN);
    pad_bytes      = MAX_LEN - i_len;
    data_aligned_d = i_data << (32'(pad_bytes) * BYTE_SIZE);
  end

  always_comb begin
    case (state_q)
      S_INIT:  cur_byte = INIT_BYTE;
      S_OPT:   cur_byte = opt_q;
      S_LEN:   cur_byte = len_q;
      S_DATA:  cur_byte = data_q[IN_DATA_SIZE-1 -: BYTE_SIZE];
      S_CSM:   cur_byte = csm_byte;
      default: cur_byte = '0;
    endcase
    bit_idx     = IDX_W'(BYTE_SIZE - int'(bit_cnt_q));
    is_data_bit = (bit_cnt_q != 4'd0) && (bit_cnt_q != BIT_LAST);
    if (bit_cnt_q == 4'd0) begin
      tx_d = 1'b0;
    end else if (is_data_bit) begin
      tx_d = cur_byte[bit_idx];
    end else begin
      tx_d = 1'b1;
    end
  end

`ifdef SYNC_UART_TX_CRC_EN
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic        crc_upd;

  // Only payload-carrying bits of OPT/LEN/DATA feed the CRC; it is frozen in CSM.
  always_comb begin
    crc_upd = baud_en && is_data_bit && (state_q inside {S_OPT, S_LEN, S_DATA});
    crc_d   = {crc_q[30:0], 1'b0} ^ ((crc_q[31] ^ tx_d) ? CRC_POLY : 32'h0);
    case (byte_cnt_q[1:0])
      2'd0:    csm_byte = BYTE_SIZE'(crc_q[31:24]);
      2'd1:    csm_byte = BYTE_SIZE'(crc_q[23:16]);
      2'd2:    csm_byte = BYTE_SIZE'(crc_q[15:8]);
      default: csm_byte = BYTE_SIZE'(crc_q[7:0]);
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      crc_q <= '0;
    end else if (accept && len_ok) begin
      crc_q <= CRC_INIT;
    end else if (crc_upd) begin
      crc_q <= crc_d;
    end
  end
`else
  assign csm_byte = '0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      opt_q      <= '0;
      len_q      <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (len_ok) begin
              state_q    <= S_INIT;
              ready_q    <= 1'b0;
              busy_q     <= 1'b1;
              opt_q      <= i_opt;
              len_q      <= i_len;
              data_q     <= data_aligned_d;
              bit_cnt_q  <= '0;
              byte_cnt_q <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          if (baud_en) begin
            tx_q <= tx_d;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              case (state_q)
                S_INIT: state_q <= S_OPT;
                S_OPT:  state_q <= S_LEN;
                S_LEN:  state_q <= S_DATA;
                S_DATA: begin
                  data_q <= data_q << BYTE_SIZE;
                  if (byte_cnt_q == len_q - 1'b1) begin
                    byte_cnt_q <= '0;
                    state_q    <= S_CSM;
                  end else begin
                    byte_cnt_q <= byte_cnt_q + 1'b1;
                  end
                end
                S_CSM: begin
                  if (byte_cnt_q == CSM_LAST) begin
                    byte_cnt_q <= '0;
                    state_q    <= S_DONE;
                    done_q     <= 1'b1;
                  end else begin
                    byte_cnt_q <= byte_cnt_q + 1'b1;
                  end
                end
                default: state_q <= S_IDLE;
              endcase
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_uart_tx.sv
// ============================================================================
// tb_sync_uart_tx : directed bench with a line receiver model and CRC model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sync_uart_tx;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        baud_en = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [7:0]  i_opt = 8'h00;
  logic [7:0]  i_len = 8'h00;
  logic [63:0] i_data = 64'h0;
  logic        o_tx;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  always #5 CLK = ~CLK;

  sync_uart_tx dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .baud_en (baud_en),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_opt   (i_opt),
    .i_len   (i_len),
    .i_data  (i_data),
    .o_tx    (o_tx),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] rx_bytes[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] rx_shift = 8'h00;
  int         rx_bitpos = 0;
  int         tick_cnt = 0;
  int         done_tick = 0;
  int         err_cnt = 0;
  int         done_cnt = 0;
  bit         frame_active = 1'b0;
  bit         done_flag = 1'b0;
  bit         stall = 1'b0;
  bit         tx_low_seen = 1'b0;
  bit         ready_low_seen = 1'b0;
  logic [1:0] phase = 2'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  task automatic rx_tick(input logic b);
    if (frame_active) tick_cnt++;
    if (rx_bitpos == 0) begin
      if (b === 1'b0) begin
        if (!frame_active) begin
          frame_active = 1'b1;
          tick_cnt     = 1;
        end
        rx_bitpos = 1;
      end
    end else if (rx_bitpos <= 8) begin
      rx_shift  = {rx_shift[6:0], b};
      rx_bitpos = rx_bitpos + 1;
    end else begin
      check("stop_bit", 64'(b), 64'd1);
      rx_bytes.push_back(rx_shift);
      rx_bitpos = 0;
    end
  endtask

  // One clock: baud strobe every 4th cycle unless stalled, outputs sampled 1 after the edge.
  task automatic step();
    @(negedge CLK);
    baud_en = !stall && (phase == 2'd3);
    phase   = phase + 2'd1;
    @(posedge CLK);
    #1;
    if (o_tx !== 1'b1) tx_low_seen = 1'b1;
    if (o_ready !== 1'b1) ready_low_seen = 1'b1;
    if (o_err === 1'b1) err_cnt++;
    if (baud_en) rx_tick(o_tx);
    if (o_done === 1'b1) begin
      done_cnt++;
      done_flag    = 1'b1;
      done_tick    = tick_cnt;
      frame_active = 1'b0;
      rx_bitpos    = 0;
    end
  endtask

  task automatic start_frame(input logic [7:0] opt, input logic [7:0] len, input logic [63:0] data);
    logic [31:0] crc;
    logic [7:0]  b;
    int          guard;
    crc          = 32'hFFFF_FFFF;
    guard        = 0;
    exp_bytes    = {};
    rx_bytes     = {};
    done_flag    = 1'b0;
    frame_active = 1'b0;
    rx_bitpos    = 0;
    exp_bytes.push_back(8'h7E);
    exp_bytes.push_back(opt);
    exp_bytes.push_back(len);
    crc = crc_step(crc, opt);
    crc = crc_step(crc, len);
    for (int k = 0; k < int'(len); k++) begin
      b   = data[8*(int'(len)-k)-1 -: 8];
      exp_bytes.push_back(b);
      crc = crc_step(crc, b);
    end
`ifdef SYNC_UART_TX_CRC_EN
    for (int k = 3; k >= 0; k--) exp_bytes.push_back(crc[8*k +: 8]);
`else
    repeat (4) exp_bytes.push_back(8'h00);
`endif
    while (o_ready !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    check("ready_before_req", 64'(o_ready), 64'd1);
    i_valid = 1'b1;
    i_opt   = opt;
    i_len   = len;
    i_data  = data;
    step();
    i_valid = 1'b0;
    i_opt   = ~opt;
    i_len   = 8'hFF;
    i_data  = ~data;
    check("ready_drop", 64'(o_ready), 64'd0);
    check("busy_rise", 64'(o_busy), 64'd1);
    guard = 0;
    do begin
      step();
      guard++;
    end while (!baud_en && guard < 20);
    check("first_start_bit", 64'(o_tx), 64'd0);
  endtask

  task automatic finish_frame(input int len);
    logic [31:0] crc;
    logic [31:0] rx_crc;
    int          guard;
    guard = 0;
    while (!done_flag && guard < 4000) begin
      step();
      guard++;
    end
    check("done_seen", 64'(done_flag), 64'd1);
    check("done_tick", 64'(done_tick), 64'((7 + len) * 10));
    check("byte_count", 64'(rx_bytes.size()), 64'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++)
      check($sformatf("frame_byte[%0d]", i), 64'(rx_bytes[i]), 64'(exp_bytes[i]));
    if (rx_bytes.size() == 7 + len) begin
      crc = 32'hFFFF_FFFF;
      for (int i = 1; i < 3 + len; i++) crc = crc_step(crc, rx_bytes[i]);
      rx_crc = {rx_bytes[3+len], rx_bytes[4+len], rx_bytes[5+len], rx_bytes[6+len]};
`ifdef SYNC_UART_TX_CRC_EN
      check("rx_crc_match", 64'(rx_crc), 64'(crc));
`else
      check("rx_crc_zero", 64'(rx_crc), 64'd0);
`endif
    end
    step();
    check("ready_after_done", 64'(o_ready), 64'd1);
    check("busy_after_done", 64'(o_busy), 64'd0);
  endtask

  initial begin
    logic [7:0] bad_len[2];
    logic       held;
    bit         changed;
    int         guard;
    bad_len[0] = 8'd0;
    bad_len[1] = 8'd9;

    RST_N = 1'b0;
    repeat (5) step();
    check("rst_tx", 64'(o_tx), 64'd1);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    tx_low_seen = 1'b0;
    err_cnt     = 0;
    done_cnt    = 0;
    repeat (4000) step();
    check("idle_tx_high", 64'(tx_low_seen), 64'd0);
    check("idle_no_done", 64'(done_cnt), 64'd0);
    check("idle_no_err", 64'(err_cnt), 64'd0);
    check("idle_ready", 64'(o_ready), 64'd1);
    check("idle_busy", 64'(o_busy), 64'd0);

    start_frame(8'hA5, 8'd1, 64'h3C);
    finish_frame(1);

    start_frame(8'h11, 8'd8, 64'h0102_0304_0506_0708);
    finish_frame(8);

    for (int j = 0; j < 2; j++) begin
      err_cnt        = 0;
      tx_low_seen    = 1'b0;
      ready_low_seen = 1'b0;
      i_valid = 1'b1;
      i_opt   = 8'h42;
      i_len   = bad_len[j];
      i_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      i_valid = 1'b0;
      check($sformatf("err_pulse_len%0d", bad_len[j]), 64'(o_err), 64'd1);
      repeat (40) step();
      check($sformatf("err_once_len%0d", bad_len[j]), 64'(err_cnt), 64'd1);
      check($sformatf("err_tx_high_len%0d", bad_len[j]), 64'(tx_low_seen), 64'd0);
      check($sformatf("err_ready_high_len%0d", bad_len[j]), 64'(ready_low_seen), 64'd0);
      check($sformatf("err_not_busy_len%0d", bad_len[j]), 64'(o_busy), 64'd0);
    end

    start_frame(8'h3D, 8'd8, 64'hDEAD_BEEF_CAFE_F00D);
    guard = 0;
    while (rx_bytes.size() < 5 && guard < 2000) begin
      step();
      guard++;
    end
    repeat (6) step();
    stall = 1'b1;
    step();
    held    = o_tx;
    changed = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (c == 20) begin
        i_valid = 1'b1;
        i_opt   = 8'h99;
        i_len   = 8'd2;
        i_data  = 64'h1234;
      end
      step();
      if (c == 20) begin
        i_valid = 1'b0;
        check("busy_req_ready_low", 64'(o_ready), 64'd0);
      end
      if (o_tx !== held) changed = 1'b1;
    end
    check("stall_tx_held", 64'(changed), 64'd0);
    stall = 1'b0;
    finish_frame(8);
    tx_low_seen = 1'b0;
    err_cnt     = 0;
    repeat (100) step();
    check("busy_req_ignored", 64'(tx_low_seen), 64'd0);
    check("busy_req_no_err", 64'(err_cnt), 64'd0);

    start_frame(8'h77, 8'd1, 64'h9A);
    guard = 0;
    while (rx_bytes.size() < 5 && guard < 2000) begin
      step();
      guard++;
    end
    repeat (10) step();
    check("pre_reset_busy", 64'(o_busy), 64'd1);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("midrst_tx", 64'(o_tx), 64'd1);
    check("midrst_ready", 64'(o_ready), 64'd1);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_done", 64'(o_done), 64'd0);
    rx_bitpos    = 0;
    frame_active = 1'b0;
    repeat (3) step();
    @(negedge CLK);
    RST_N = 1'b1;
    start_frame(8'hC3, 8'd2, 64'hBEEF);
    finish_frame(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_uart_tx.md
Name: sync_uart_tx

Overview:
- Frame transmitter for the synchronous UART link; mirror of the frame receiver on the far end.
- Accepts one message (opt, len, packed data) per handshake and serialises it as: init byte 0x7E, opt, len, len data bytes, 4-byte CRC-32.
- Bit advance is gated by an external baud strobe (baud_en), one line bit per strobe.
- Sits between the host-side command logic and the TX pin driver.

Parameters:
- BYTE_SIZE, 8, bits per byte.
- MAX_MSG_LEN, (1<<BYTE_SIZE)-1, maximum message length; sets DATA_BYTES = $clog2(MAX_MSG_LEN) = 8.
- IN_DATA_SIZE, $clog2(MAX_MSG_LEN)*BYTE_SIZE, packed data width (64).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- baud_en  in  1  one-cycle bit strobe; all line activity advances only on cycles with baud_en=1.
- i_valid  in  1  message request.
- o_ready  out  1  block is idle and can accept a message.
- i_opt  in  BYTE_SIZE  option byte.
- i_len  in  BYTE_SIZE  number of data bytes, legal range 1..DATA_BYTES.
- i_data  in  IN_DATA_SIZE  packed payload; the last byte sent is at the LSBs.
- o_tx  out  1  serial line; idles at 1.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse after the stop bit of the last CRC byte.
- o_err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - o_tx=1, o_ready=1, o_busy=0, o_done=0, o_err=0.
  - State IDLE; all counters and the CRC register cleared.
  - Reset mid-frame aborts immediately: o_tx returns to 1 with no partial-byte completion.
- Acceptance:
  - A request is taken on a CLK edge with i_valid & o_ready.
  - i_opt, i_len and i_data are captured into internal registers; inputs are don't-care afterwards.
  - o_ready drops and o_busy rises on the next cycle.
- Illegal length: if i_len==0 or i_len>DATA_BYTES, the request is consumed, o_err pulses one cycle, and the block stays in IDLE. Nothing is transmitted.
- Byte format, per baud_en tick:
  - Start bit 0, then BYTE_SIZE data bits MSB first, then stop bit 1. That is 10 ticks per byte.
  - A 4-bit bit counter runs 0..9 and wraps to 0 on each byte boundary.
- States: IDLE, INIT, OPT, LEN, DATA, CSM, DONE.
  - IDLE -> INIT on acceptance of a legal request.
  - INIT sends 0x7E; no CRC update.
  - INIT -> OPT -> LEN -> DATA, each transition at byte end (bit counter 9 and baud_en).
  - DATA sends byte k (k=0..len-1) from i_data[8*(len-k)-1 -: 8]. A byte counter runs 0..len-1; DATA -> CSM when the byte counter is len-1 at byte end.
  - CSM sends the CRC MSB byte first, 4 bytes; CSM -> DONE at the end of the 4th byte.
  - DONE lasts one CLK cycle: o_done=1, then -> IDLE, o_ready=1.
- The first start bit is driven on the first baud_en after acceptance. If baud_en coincides with the acceptance edge, that strobe is not used.
- Total line time is (7+len)*10 baud ticks.
- o_tx is registered: it changes only on baud_en cycles and is held between strobes.
- CRC-32/MPEG-2:
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR.
  - Updated bitwise, MSB first, on the data bits of OPT, LEN and DATA bytes only.
  - Start/stop bits, the init byte and the CRC bytes themselves are excluded.
  - The CRC is frozen at entry to CSM and reinitialised on acceptance.
- i_valid while busy is ignored (o_ready=0); no queueing.
- baud_en held low stalls the frame indefinitely with o_tx stable.

Optional Feature:
- Macro SYNC_UART_TX_CRC_EN.
- Defined: CRC logic is present and the CSM bytes carry the CRC as above.
- Undefined: CRC logic is removed, the CSM bytes are sent as 0x00 x4, and frame timing is unchanged.

Test Plan:
- Reset held low for 5 cycles, then released, with no i_valid -> o_tx=1, o_ready=1, o_busy=0; no o_done or o_err for 1000 baud ticks.
- Request opt=0xA5, len=1, i_data[7:0]=0x3C, baud_en every 4th cycle:
  - Line carries 0x7E, 0xA5, 0x01, 0x3C, then 4 CRC bytes.
  - Each byte is 0 + MSB-first data + 1.
  - o_done asserts exactly 80 ticks after the first start bit.
  - CRC bytes equal the bench CRC-32/MPEG-2 of {A5,01,3C}.
- Request len=8, i_data=0x0102030405060708 -> data bytes appear in order 01..08; 150 ticks total; bench receiver model reports a CRC match.
- Illegal length: request with len=0, then a separate request with len=9 -> o_err pulses once per request, o_tx stays 1, o_ready stays high.
- Stalls and busy requests:
  - baud_en is held low for 50 cycles in the middle of the DATA state, and i_valid is pulsed while the block is busy.
  - o_tx holds its value throughout the stall.
  - The pulsed i_valid is ignored.
  - The frame completes unchanged.
- Reset mid-frame: RST_N asserted in the CSM state -> o_tx=1 immediately; after release, a new request for len=2 transmits a correct full frame.
